// File: rtl/conv_row_result_drain.sv
// conv_row_result_drain: row FIFO that drains conv result rows one pixel per beat over valid/ready.
module conv_row_result_drain #(
  parameter int N_PIX  = 46,
  parameter int N_ROWS = 46,
  parameter int N_CH   = 3,
  parameter int RES_W  = 16,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       vld_i,
  input  logic [N_PIX*RES_W-1:0]     res_i_0,
  input  logic [N_PIX*RES_W-1:0]     res_i_1,
  input  logic [N_PIX*RES_W-1:0]     res_i_2,
  input  logic                       done_i,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [N_CH*RES_W-1:0]      m_data,
  output logic [$clog2(N_PIX)-1:0]   m_col,
  output logic [$clog2(N_ROWS)-1:0]  m_row,
  output logic                       m_last,
  output logic                       frame_done,
  output logic                       overflow
);
  localparam int ROW_W = N_PIX * RES_W;
  localparam int COL_W = $clog2(N_PIX);
  localparam int RW    = $clog2(N_ROWS);
  localparam int PW    = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state_q, state_d;
  logic [3*ROW_W-1:0] mem_q [DEPTH];
  logic [3*ROW_W-1:0] head;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic done_q, done_d, fd_q, fd_d, ovf_q, ovf_d;
  logic end_col, xfer, pop, push;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    head     = mem_q[rd_q];
    m_valid  = state_q == STREAM;
    end_col  = col_q == COL_W'(N_PIX - 1);
    xfer     = m_valid && m_ready;
    pop      = xfer && end_col;
    // a full FIFO still accepts a row when the head pops on the same edge
    push     = vld_i && (cnt_q != CW'(DEPTH) || pop);
    wr_d     = push ? inc(wr_q) : wr_q;
    rd_d     = pop ? inc(rd_q) : rd_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    col_d    = xfer ? (end_col ? '0 : col_q + 1'b1) : col_q;
    fd_d     = done_q && cnt_d == '0;
    row_d    = fd_d ? '0 : pop ? (row_q == RW'(N_ROWS - 1) ? '0 : row_q + 1'b1) : row_q;
    done_d   = fd_d ? 1'b0 : done_q | done_i;
    ovf_d    = ovf_q | (vld_i && !push);
    state_d  = state_q == IDLE ? (push ? STREAM : IDLE) :
               (pop && !push && cnt_q == CW'(1)) ? IDLE : STREAM;
    m_data   = m_valid ? {head[2*ROW_W + int'(col_q)*RES_W +: RES_W],
                          head[ROW_W + int'(col_q)*RES_W +: RES_W],
                          head[int'(col_q)*RES_W +: RES_W]} : '0;
    m_col      = col_q;
    m_row      = row_q;
    m_last     = m_valid && end_col && row_q == RW'(N_ROWS - 1);
    frame_done = fd_q;
    overflow   = ovf_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
      fd_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      done_q  <= done_d;
      fd_q    <= fd_d;
      ovf_q   <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {res_i_2, res_i_1, res_i_0};
  end
endmodule
